round_key_sequencer: RTL and testbench

//  Collects ROUND round keys from the key source over a valid/ready handshake and stores them.
//  On each start request, issues the stored keys one per round to the cipher round datapath.

---
 rtl/round_key_sequencer_if.sv | 29 ++
 rtl/round_key_sequencer.sv | 120 ++++++++++++
 tb/tb_round_key_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_key_sequencer_if.sv
// Handshake bundle between the round-key sequencer, its key source and the round datapath.
// master = surrounding environment, slave = sequencer.
interface round_key_sequencer_if #(
   parameter int unsigned KEY_SIZE = 128,
   parameter int unsigned IDX_W    = 3
);
   logic                clear;
   logic                key_valid;
   logic                key_ready;
   logic [KEY_SIZE-1:0] key_in;
   logic                loaded;
   logic                start;
   logic                busy;
   logic                rk_valid;
   logic                rk_ready;
   logic [KEY_SIZE-1:0] rk_data;
   logic [IDX_W-1:0]    rk_idx;
   logic                done;

   modport master (
      output clear, key_valid, key_in, start, rk_ready,
      input  key_ready, loaded, busy, rk_valid, rk_data, rk_idx, done
   );

   modport slave (
      input  clear, key_valid, key_in, start, rk_ready,
      output key_ready, loaded, busy, rk_valid, rk_data, rk_idx, done
   );
endinterface

// File: rtl/round_key_sequencer.sv
// Stores ROUND round keys and replays them to the round datapath once per start request.
// Optional ROUND_KEY_REVERSE_EN adds a 'decrypt' input selecting reverse issue order.
module round_key_sequencer #(
   parameter int unsigned ROUND    = 5,
   parameter int unsigned KEY_SIZE = 128,
   parameter int unsigned IDX_W    = 3
) (
   input logic                  clk,
   input logic                  reset_n,
`ifdef ROUND_KEY_REVERSE_EN
   input logic                  decrypt,
`endif
   round_key_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StLoad, StArmed, StRun} state_e;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUND - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [KEY_SIZE-1:0] data_q, data_d;
   logic [KEY_SIZE-1:0] keys_q [ROUND];
   logic [KEY_SIZE-1:0] keys_d [ROUND];
   logic                done_q, done_d;
   logic                rev_q, rev_d;
   logic                rev_sel;
   logic                is_last;

`ifdef ROUND_KEY_REVERSE_EN
   assign rev_sel = decrypt;
`else
   assign rev_sel = 1'b0;
`endif

   // Final key depends on the direction latched at start.
   assign is_last = rev_q ? (idx_q == '0) : (idx_q == LastIdx);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      keys_d  = keys_q;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      rev_d   = rev_q;
      if (bus.clear) begin
         state_d = StLoad;
         cnt_d   = '0;
         keys_d  = '{default: '0};
         idx_d   = '0;
         data_d  = '0;
         rev_d   = 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (bus.key_valid) begin
                  keys_d[cnt_q] = bus.key_in;
                  if (cnt_q == LastIdx) begin
                     cnt_d   = '0;
                     state_d = StArmed;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StArmed: begin
               if (bus.start) begin
                  state_d = StRun;
                  rev_d   = rev_sel;
                  idx_d   = rev_sel ? LastIdx : '0;
                  data_d  = keys_q[idx_d];
               end
            end
            StRun: begin
               if (bus.rk_ready) begin
                  if (is_last) begin
                     state_d = StArmed;
                     done_d  = 1'b1;
                  end else begin
                     idx_d  = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
                     data_d = keys_q[idx_d];
                  end
               end
            end
            default: state_d = StLoad;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StLoad;
         cnt_q   <= '0;
         keys_q  <= '{default: '0};
         idx_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         rev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         keys_q  <= keys_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         done_q  <= done_d;
         rev_q   <= rev_d;
      end
   end

   assign bus.key_ready = (state_q == StLoad);
   assign bus.loaded    = (state_q == StArmed) || (state_q == StRun);
   assign bus.busy      = (state_q == StRun);
   assign bus.rk_valid  = (state_q == StRun);
   assign bus.rk_data   = data_q;
   assign bus.rk_idx    = idx_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer: queue-based reference model checked every cycle,
// plus literal expectations per scenario. Reverse-order scenario needs ROUND_KEY_REVERSE_EN.
module tb_round_key_sequencer;
   localparam int unsigned ROUND    = 5;
   localparam int unsigned KEY_SIZE = 128;
   localparam int unsigned IDX_W    = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic decrypt = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   round_key_sequencer_if #(.KEY_SIZE(KEY_SIZE), .IDX_W(IDX_W)) bus ();

   round_key_sequencer #(.ROUND(ROUND), .KEY_SIZE(KEY_SIZE), .IDX_W(IDX_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef ROUND_KEY_REVERSE_EN
      .decrypt (decrypt),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [KEY_SIZE-1:0] key_of(input int base, input int k);
      logic [7:0] b;
      b = 8'(base * k);
      return {16{b}};
   endfunction

   task automatic chk(input string name, input logic [KEY_SIZE-1:0] act,
                      input logic [KEY_SIZE-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored key list, count loaded, queue of indices still to issue.
   logic [KEY_SIZE-1:0] stored [ROUND];
   int                  n_loaded = 0;
   int                  pending [$];
   bit                  m_done = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      bit rev;
      if (!reset_n) begin
         n_loaded = 0;
         foreach (stored[i]) stored[i] = '0;
         pending.delete();
         m_done = 1'b0;
      end else if (bus.clear) begin
         n_loaded = 0;
         foreach (stored[i]) stored[i] = '0;
         pending.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (n_loaded < ROUND) begin
            if (bus.key_valid) begin
               stored[n_loaded] = bus.key_in;
               n_loaded++;
            end
         end else if (pending.size() == 0) begin
            if (bus.start) begin
`ifdef ROUND_KEY_REVERSE_EN
               rev = decrypt;
`else
               rev = 1'b0;
`endif
               for (int i = 0; i < ROUND; i++) pending.push_back(rev ? ROUND - 1 - i : i);
            end
         end else if (bus.rk_ready) begin
            void'(pending.pop_front());
            if (pending.size() == 0) m_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_key_ready", bus.key_ready, (n_loaded < ROUND));
         chk("m_loaded", bus.loaded, (n_loaded == ROUND));
         chk("m_busy", bus.busy, (pending.size() != 0));
         chk("m_rk_valid", bus.rk_valid, (pending.size() != 0));
         chk("m_done", bus.done, m_done);
         if (pending.size() != 0) begin
            chk("m_rk_idx", bus.rk_idx, pending[0]);
            chk("m_rk_data", bus.rk_data, stored[pending[0]]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int base, input int n);
      for (int k = 1; k <= n; k++) begin
         bus.key_valid = 1'b1;
         bus.key_in    = key_of(base, k);
         step();
      end
      bus.key_valid = 1'b0;
   endtask

   // One full sequence with optional stall of stall_cycles at index stall_idx.
   task automatic issue(input string name, input int base, input bit rev,
                        input int stall_idx, input int stall_cycles);
      int e;
      decrypt      = rev;
      bus.start    = 1'b1;
      bus.rk_ready = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < ROUND; i++) begin
         e = rev ? ROUND - 1 - i : i;
         if (e == stall_idx) begin
            bus.rk_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               chk({name, "_stall_idx"}, bus.rk_idx, e);
               chk({name, "_stall_data"}, bus.rk_data, key_of(base, e + 1));
               step();
            end
            bus.rk_ready = 1'b1;
         end
         chk({name, "_valid"}, bus.rk_valid, 1'b1);
         chk({name, "_idx"}, bus.rk_idx, e);
         chk({name, "_data"}, bus.rk_data, key_of(base, e + 1));
         step();
      end
      chk({name, "_done"}, bus.done, 1'b1);
      chk({name, "_valid_off"}, bus.rk_valid, 1'b0);
      step();
      chk({name, "_done_pulse"}, bus.done, 1'b0);
      chk({name, "_busy_off"}, bus.busy, 1'b0);
      chk({name, "_loaded"}, bus.loaded, 1'b1);
   endtask

   initial begin
      bus.clear     = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_in    = '0;
      bus.start     = 1'b0;
      bus.rk_ready  = 1'b0;
      step();
      step();
      chk("rst_key_ready", bus.key_ready, 1'b1);
      chk("rst_loaded", bus.loaded, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rk_valid", bus.rk_valid, 1'b0);
      chk("rst_rk_data", bus.rk_data, '0);
      chk("rst_rk_idx", bus.rk_idx, '0);
      chk("rst_done", bus.done, 1'b0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      step();

      // T1: load five keys, sixth key_valid is refused
      for (int k = 1; k <= ROUND; k++) begin
         chk("t1_loaded_early", bus.loaded, 1'b0);
         bus.key_valid = 1'b1;
         bus.key_in    = key_of(8'h11, k);
         step();
      end
      bus.key_in = key_of(8'h11, 6);
      chk("t1_loaded", bus.loaded, 1'b1);
      chk("t1_key_ready_6th", bus.key_ready, 1'b0);
      step();
      chk("t1_key_ready_hold", bus.key_ready, 1'b0);
      bus.key_valid = 1'b0;
      step();

      // T2: back-to-back issue
      issue("t2", 8'h11, 1'b0, -1, 0);

      // T3: three-cycle stall at index 2
      issue("t3", 8'h11, 1'b0, 2, 3);

      // T4: clear beats start at index 1, then reload and run
      bus.start    = 1'b1;
      bus.rk_ready = 1'b1;
      step();
      bus.start = 1'b0;
      chk("t4_idx0", bus.rk_idx, 0);
      step();
      chk("t4_idx1", bus.rk_idx, 1);
      bus.clear = 1'b1;
      bus.start = 1'b1;
      step();
      bus.clear = 1'b0;
      bus.start = 1'b0;
      chk("t4_rk_valid", bus.rk_valid, 1'b0);
      chk("t4_loaded", bus.loaded, 1'b0);
      chk("t4_done", bus.done, 1'b0);
      chk("t4_key_ready", bus.key_ready, 1'b1);
      chk("t4_rk_data_zero", bus.rk_data, '0);
      step();
      chk("t4_no_done", bus.done, 1'b0);
      load(8'h21, ROUND);
      issue("t4_reload", 8'h21, 1'b0, -1, 0);

      // T5: reset in the middle of loading
      load(8'h11, 3);
      reset_n = 1'b0;
      #1;
      chk("t5_key_ready", bus.key_ready, 1'b1);
      chk("t5_loaded", bus.loaded, 1'b0);
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_rk_valid", bus.rk_valid, 1'b0);
      chk("t5_rk_data", bus.rk_data, '0);
      chk("t5_rk_idx", bus.rk_idx, '0);
      chk("t5_done", bus.done, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      load(8'h12, ROUND);
      chk("t5_loaded_after", bus.loaded, 1'b1);
      issue("t5_run", 8'h12, 1'b0, -1, 0);

`ifdef ROUND_KEY_REVERSE_EN
      // T6: reverse order
      issue("t6", 8'h12, 1'b1, -1, 0);
      issue("t6_fwd", 8'h12, 1'b0, -1, 0);
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
